// File: rtl/des_output_stage.sv
// DES back end: forms the pre-output block from the round-16 halves, applies IP^-1,
// and streams the 64-bit cipher block out as 8 bytes on a valid/ready interface.
module des_output_stage #(
  parameter bit SWAP_HALVES = 1'b1,
  parameter bit BYTE_REV    = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_l16,
  input  logic [31:0] i_r16,
  input  logic        i_valid,
  output logic        o_in_ready,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  input  logic        i_byte_ready,
  output logic        o_last,
  input  logic        i_flush,
  output logic        o_busy
);

  // state   | meaning
  // ST_IDLE | no block held, ready for a new block
  // ST_SEND | hold register streaming bytes, cnt_q = byte being offered
  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] hold_q, hold_d;
  logic        rdy_en_q;

  logic [63:0] pre_out;
  logic [63:0] perm_c;
  logic        send;
  logic        last_byte;
  logic        accept;
  logic        byte_hs;
  logic [2:0]  byte_sel;
  logic [7:0]  sel_byte;

  assign pre_out = SWAP_HALVES ? {i_l16, i_r16} : {i_r16, i_l16};

  // IP^-1, one row of eight output bits per iteration
  always_comb begin
    perm_c = '0;
    for (int j = 0; j < 8; j++) begin
      perm_c[8*j+0] = pre_out[39-j];
      perm_c[8*j+1] = pre_out[7-j];
      perm_c[8*j+2] = pre_out[47-j];
      perm_c[8*j+3] = pre_out[15-j];
      perm_c[8*j+4] = pre_out[55-j];
      perm_c[8*j+5] = pre_out[23-j];
      perm_c[8*j+6] = pre_out[63-j];
      perm_c[8*j+7] = pre_out[31-j];
    end
  end

  assign send      = (state_q == ST_SEND);
  assign last_byte = (cnt_q == 3'd7);

  // rdy_en_q keeps ready low until the first edge after reset release
  assign o_in_ready   = rdy_en_q & ~i_flush & (~send | (last_byte & i_byte_ready));
  assign accept       = i_valid & o_in_ready;
  assign byte_hs      = send & i_byte_ready;
  assign o_byte_valid = send;
  assign o_last       = send & last_byte;
  assign o_busy       = send;

  assign byte_sel = BYTE_REV ? ~cnt_q : cnt_q;

  always_comb begin
    sel_byte = hold_q[8*byte_sel +: 8];
    o_byte   = '0;
    for (int b = 0; b < 8; b++) begin
      o_byte[7-b] = send & sel_byte[b];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    if (i_flush) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = ST_SEND;
            cnt_d   = 3'd0;
            hold_d  = perm_c;
          end
        end
        ST_SEND: begin
          if (byte_hs) begin
            if (last_byte) begin
              cnt_d = 3'd0;
              if (accept) begin
                state_d = ST_SEND;
                hold_d  = perm_c;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      hold_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule
